// File: rtl/parking_gate_ctrl.sv
// Parking gate front-end: sensor synchronise/debounce, keypad code latch,
// request serialisation towards the parking core and barrier timing.
// Exit requests win over entry requests because they free a space.
module parking_gate_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int GATE_CYCLES  = 8,
  parameter int CODE_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic       key_valid,
  input  logic [2:0] key_slot,
  input  logic [7:0] key_code,
  input  logic       can_park,
  output logic       car_arrive,
  output logic       car_exit,
  output logic [2:0] exit_from,
  output logic [7:0] exit_code,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       full_alarm,
  output logic       code_timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENTRY_CHK  = 3'd1,
    ENTRY_OPEN = 3'd2,
    EXIT_WAIT  = 3'd3,
    EXIT_OPEN  = 3'd4
  } state_t;

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int TMAX = (GATE_CYCLES > CODE_TIMEOUT) ? GATE_CYCLES : CODE_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(CODE_TIMEOUT - 1);

  // index 0 = entry loop, index 1 = exit loop
  logic [1:0]    raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    deb_r;
  logic [1:0]    deb_prev_r;
  logic [DW-1:0] deb_cnt_r [2];
  logic [1:0]    rise_s;

  logic          entry_pend_r;
  logic          exit_pend_r;
  logic          code_vld_r;
  logic [2:0]    slot_r;
  logic [7:0]    code_r;
  logic [2:0]    eff_slot_s;
  logic [7:0]    eff_code_s;

  state_t        state_r;
  state_t        state_nx_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_nx_s;
  logic          arrive_s;
  logic          exit_s;
  logic          alarm_s;
  logic          timeout_s;

  logic          car_arrive_r;
  logic          car_exit_r;
  logic [2:0]    exit_from_r;
  logic [7:0]    exit_code_r;
  logic          entry_gate_r;
  logic          exit_gate_r;
  logic          full_alarm_r;
  logic          code_timeout_r;
  logic          busy_r;

  assign raw_s  = {exit_sensor, entry_sensor};
  assign rise_s = deb_r & ~deb_prev_r;

  // A key strobe in the same cycle as the EXIT_WAIT check takes precedence
  // over the previously latched code.
  assign eff_slot_s = key_valid ? key_slot : slot_r;
  assign eff_code_s = key_valid ? key_code : code_r;

  // Two-flop synchronisers followed by a run-length debouncer per loop sensor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r      <= 2'b00;
      sync2_r      <= 2'b00;
      deb_r        <= 2'b00;
      deb_prev_r   <= 2'b00;
      deb_cnt_r[0] <= '0;
      deb_cnt_r[1] <= '0;
    end else begin
      sync1_r    <= raw_s;
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Pending-request flags: a new rising edge wins over the service clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_pend_r <= 1'b0;
      exit_pend_r  <= 1'b0;
    end else begin
      entry_pend_r <= rise_s[0] ? 1'b1 : ((state_r == ENTRY_CHK) ? 1'b0 : entry_pend_r);
      exit_pend_r  <= rise_s[1] ? 1'b1 : ((state_r == EXIT_WAIT) ? 1'b0 : exit_pend_r);
    end
  end

  // Keypad latch: newest strobe overwrites, consumption by car_exit clears valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_r     <= 3'd0;
      code_r     <= 8'd0;
      code_vld_r <= 1'b0;
    end else begin
      if (key_valid) begin
        slot_r <= key_slot;
        code_r <= key_code;
      end else begin
        slot_r <= slot_r;
        code_r <= code_r;
      end
      code_vld_r <= exit_s ? 1'b0 : (key_valid ? 1'b1 : code_vld_r);
    end
  end

  // State register and shared gate / code-wait timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      timer_r <= '0;
    end else begin
      state_r <= state_nx_s;
      timer_r <= timer_nx_s;
    end
  end

  // Next-state logic and single-cycle event strobes.
  always_comb begin
    state_nx_s = state_r;
    timer_nx_s = timer_r;
    arrive_s   = 1'b0;
    exit_s     = 1'b0;
    alarm_s    = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE: begin
        timer_nx_s = '0;
        if (exit_pend_r) begin
          state_nx_s = EXIT_WAIT;
        end else if (entry_pend_r) begin
          state_nx_s = ENTRY_CHK;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ENTRY_CHK: begin
        timer_nx_s = '0;
        if (can_park) begin
          state_nx_s = ENTRY_OPEN;
          arrive_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
          alarm_s    = 1'b1;
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (timer_r == GATE_LAST) begin
          state_nx_s = IDLE;
          timer_nx_s = '0;
        end else begin
          timer_nx_s = timer_r + TW'(1);
        end
      end
      EXIT_WAIT: begin
        if (key_valid || code_vld_r) begin
          state_nx_s = EXIT_OPEN;
          timer_nx_s = '0;
          exit_s     = 1'b1;
        end else if (timer_r == WAIT_LAST) begin
          state_nx_s = IDLE;
          timer_nx_s = '0;
          timeout_s  = 1'b1;
        end else begin
          timer_nx_s = timer_r + TW'(1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        timer_nx_s = '0;
      end
    endcase
  end

  // Registered outputs; exit_from / exit_code hold outside the car_exit cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      car_arrive_r   <= 1'b0;
      car_exit_r     <= 1'b0;
      exit_from_r    <= 3'd0;
      exit_code_r    <= 8'd0;
      entry_gate_r   <= 1'b0;
      exit_gate_r    <= 1'b0;
      full_alarm_r   <= 1'b0;
      code_timeout_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      car_arrive_r   <= arrive_s;
      car_exit_r     <= exit_s;
      if (exit_s) begin
        exit_from_r <= eff_slot_s;
        exit_code_r <= eff_code_s;
      end else begin
        exit_from_r <= exit_from_r;
        exit_code_r <= exit_code_r;
      end
      entry_gate_r   <= (state_nx_s == ENTRY_OPEN);
      exit_gate_r    <= (state_nx_s == EXIT_OPEN);
      full_alarm_r   <= alarm_s;
      code_timeout_r <= timeout_s;
      busy_r         <= (state_r != IDLE);
    end
  end

  assign car_arrive      = car_arrive_r;
  assign car_exit        = car_exit_r;
  assign exit_from       = exit_from_r;
  assign exit_code       = exit_code_r;
  assign entry_gate_open = entry_gate_r;
  assign exit_gate_open  = exit_gate_r;
  assign full_alarm      = full_alarm_r;
  assign code_timeout    = code_timeout_r;
  assign busy            = busy_r;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural model of the gate.
module tb_parking_gate_ctrl;

  localparam int DEB  = 4;
  localparam int GATE = 8;
  localparam int CTO  = 32;

  localparam int M_IDLE = 0;
  localparam int M_CHK  = 1;
  localparam int M_IN   = 2;
  localparam int M_WAIT = 3;
  localparam int M_OUT  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       entry_sensor, exit_sensor, key_valid, can_park;
  logic [2:0] key_slot;
  logic [7:0] key_code;
  logic       car_arrive, car_exit, entry_gate_open, exit_gate_open;
  logic       full_alarm, code_timeout, busy;
  logic [2:0] exit_from;
  logic [7:0] exit_code;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_phase, m_timer;
  bit          m_epend, m_xpend, m_cvld;
  bit [2:0]    m_cslot;
  bit [7:0]    m_ccode;
  bit          m_lvl_e, m_lvl_x, m_rose_e, m_rose_x;
  bit [15:0]   h_e, h_x;
  // expected outputs
  bit          e_arrive, e_exit, e_alarm, e_to, e_busy, e_egate, e_xgate;
  bit [2:0]    e_from;
  bit [7:0]    e_code;
  // pulse / level counters observed on the DUT
  int n_arrive, n_exit, n_alarm, n_to, n_egate, n_xgate;

  always #5 clk = ~clk;

  parking_gate_ctrl #(.DEB_CYCLES(DEB), .GATE_CYCLES(GATE), .CODE_TIMEOUT(CTO)) dut (
    .clk(clk), .rst_n(rst_n),
    .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .key_valid(key_valid), .key_slot(key_slot), .key_code(key_code),
    .can_park(can_park),
    .car_arrive(car_arrive), .car_exit(car_exit),
    .exit_from(exit_from), .exit_code(exit_code),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .full_alarm(full_alarm), .code_timeout(code_timeout), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // True when each of the last DEB synchronised samples differs from lvl.
  function automatic bit all_differ(input bit [15:0] h, input bit lvl);
    for (int i = 1; i <= DEB; i++) begin
      if (h[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    bit take;
    bit nr;
    if (!rst_n) begin
      m_phase = M_IDLE; m_timer = 0;
      m_epend = 0; m_xpend = 0; m_cvld = 0; m_cslot = 0; m_ccode = 0;
      m_lvl_e = 0; m_lvl_x = 0; m_rose_e = 0; m_rose_x = 0; h_e = 0; h_x = 0;
      e_arrive = 0; e_exit = 0; e_alarm = 0; e_to = 0; e_busy = 0;
      e_egate = 0; e_xgate = 0; e_from = 0; e_code = 0;
      return;
    end
    e_busy = (m_phase != M_IDLE);
    e_arrive = 0; e_exit = 0; e_alarm = 0; e_to = 0; take = 0;
    case (m_phase)
      M_IDLE: begin
        if (m_xpend) begin m_phase = M_WAIT; m_timer = CTO; end
        else if (m_epend) m_phase = M_CHK;
      end
      M_CHK: begin
        m_epend = 0;
        if (can_park) begin e_arrive = 1; m_phase = M_IN; m_timer = GATE; end
        else begin e_alarm = 1; m_phase = M_IDLE; end
      end
      M_IN, M_OUT: begin
        m_timer--;
        if (m_timer == 0) m_phase = M_IDLE;
      end
      M_WAIT: begin
        m_xpend = 0;
        if (key_valid || m_cvld) begin
          take = 1; e_exit = 1;
          e_from = key_valid ? key_slot : m_cslot;
          e_code = key_valid ? key_code : m_ccode;
          m_phase = M_OUT; m_timer = GATE;
        end else begin
          m_timer--;
          if (m_timer == 0) begin e_to = 1; m_phase = M_IDLE; end
        end
      end
      default: m_phase = M_IDLE;
    endcase
    if (key_valid) begin m_cslot = key_slot; m_ccode = key_code; m_cvld = 1; end
    if (take) m_cvld = 0;
    if (m_rose_e) m_epend = 1;
    if (m_rose_x) m_xpend = 1;
    e_egate = (m_phase == M_IN);
    e_xgate = (m_phase == M_OUT);
    nr = 0;
    if (all_differ(h_e, m_lvl_e)) begin m_lvl_e = ~m_lvl_e; nr = m_lvl_e; end
    m_rose_e = nr;
    h_e = {h_e[14:0], entry_sensor};
    nr = 0;
    if (all_differ(h_x, m_lvl_x)) begin m_lvl_x = ~m_lvl_x; nr = m_lvl_x; end
    m_rose_x = nr;
    h_x = {h_x[14:0], exit_sensor};
  endtask

  task automatic compare_all();
    check_eq("car_arrive", 32'(car_arrive), 32'(e_arrive));
    check_eq("car_exit", 32'(car_exit), 32'(e_exit));
    check_eq("exit_from", 32'(exit_from), 32'(e_from));
    check_eq("exit_code", 32'(exit_code), 32'(e_code));
    check_eq("entry_gate_open", 32'(entry_gate_open), 32'(e_egate));
    check_eq("exit_gate_open", 32'(exit_gate_open), 32'(e_xgate));
    check_eq("full_alarm", 32'(full_alarm), 32'(e_alarm));
    check_eq("code_timeout", 32'(code_timeout), 32'(e_to));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("arrive_exit_excl", 32'(car_arrive & car_exit), 32'd0);
    n_arrive += int'(car_arrive);
    n_exit   += int'(car_exit);
    n_alarm  += int'(full_alarm);
    n_to     += int'(code_timeout);
    n_egate  += int'(entry_gate_open);
    n_xgate  += int'(exit_gate_open);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic clr_counts();
    n_arrive = 0; n_exit = 0; n_alarm = 0; n_to = 0; n_egate = 0; n_xgate = 0;
  endtask

  task automatic strobe_key(input logic [2:0] s, input logic [7:0] c);
    key_valid = 1'b1; key_slot = s; key_code = c;
    cyc(1);
    key_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0;
    key_valid = 1'b0; key_slot = 3'd0; key_code = 8'd0; can_park = 1'b1;
    clr_counts();
    @(negedge clk);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    // entry with short glitches, then held
    clr_counts();
    entry_sensor = 1'b1; cyc(2); entry_sensor = 1'b0; cyc(3);
    entry_sensor = 1'b1; cyc(3); entry_sensor = 1'b0; cyc(3);
    entry_sensor = 1'b1; cyc(30); entry_sensor = 1'b0; cyc(12);
    check_eq("glitch_arrive_cnt", 32'(n_arrive), 32'd1);
    check_eq("entry_gate_cycles", 32'(n_egate), 32'(GATE));

    // refused arrival
    clr_counts();
    can_park = 1'b0;
    entry_sensor = 1'b1; cyc(10); entry_sensor = 1'b0; cyc(15);
    check_eq("full_alarm_cnt", 32'(n_alarm), 32'd1);
    check_eq("full_no_arrive", 32'(n_arrive), 32'd0);
    check_eq("full_no_gate", 32'(n_egate), 32'd0);
    can_park = 1'b1;

    // exit with code latched beforehand
    clr_counts();
    strobe_key(3'd3, 8'd11);
    exit_sensor = 1'b1; cyc(10); exit_sensor = 1'b0; cyc(20);
    check_eq("exit_cnt", 32'(n_exit), 32'd1);
    check_eq("exit_gate_cycles", 32'(n_xgate), 32'(GATE));
    check_eq("exit_from_hold", 32'(exit_from), 32'd3);
    check_eq("exit_code_hold", 32'(exit_code), 32'd11);

    // exit without any code
    clr_counts();
    exit_sensor = 1'b1; cyc(10); exit_sensor = 1'b0; cyc(40);
    check_eq("timeout_cnt", 32'(n_to), 32'd1);
    check_eq("timeout_no_exit", 32'(n_exit), 32'd0);

    // simultaneous entry and exit, code latched
    clr_counts();
    strobe_key(3'd5, 8'hA5);
    entry_sensor = 1'b1; exit_sensor = 1'b1; cyc(10);
    entry_sensor = 1'b0; exit_sensor = 1'b0; cyc(40);
    check_eq("simul_exit_cnt", 32'(n_exit), 32'd1);
    check_eq("simul_arrive_cnt", 32'(n_arrive), 32'd1);

    // reset during ENTRY_OPEN
    clr_counts();
    entry_sensor = 1'b1; cyc(12);
    check_eq("pre_reset_gate", 32'(entry_gate_open), 32'd1);
    entry_sensor = 1'b0; rst_n = 1'b0; cyc(1);
    check_eq("reset_gate_closed", 32'(entry_gate_open), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; cyc(20);
    check_eq("reset_no_reopen", 32'(n_arrive), 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) entry_sensor = ~entry_sensor;
      if ($urandom_range(0, 9) == 0) exit_sensor = ~exit_sensor;
      key_valid = ($urandom_range(0, 24) == 0);
      key_slot  = 3'($urandom);
      key_code  = 8'($urandom);
      can_park  = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 799) != 0);
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
